unpool_sequencer: RTL and testbench

- Control sequencer for the 2x2 unpooling datapath at one pyramid level.
- Tracks the full-resolution raster coordinates of the incoming stream and classifies each position as UL, UR, LL or LR.
- Drives the datapath's hold register, a one-row line buffer (synchronous read, 1-cycle latency) and its output mux. Emits the output valid and coordinates.
- Replaces free-running delay-line timing with explicit, checkable sequencing. Includes frame sync and error detection.

---
 rtl/unpool_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_unpool_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/unpool_sequencer.sv
// rtl/unpool_sequencer.sv - 2x2 unpooling control sequencer: raster tracking, hold/line-buffer strobes, output mux timing
module unpool_sequencer #(
  parameter int W_WIDTH  = 640,
  parameter int W_HEIGHT = 480,
  parameter int LEVEL    = 1,
  parameter int H_BITW   = $clog2(W_WIDTH),
  parameter int V_BITW   = $clog2(W_HEIGHT),
  parameter int A_BITW   = ($clog2(W_WIDTH >> (LEVEL + 1)) > 1) ? $clog2(W_WIDTH >> (LEVEL + 1)) : 1
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              in_enable,
  input  logic [V_BITW-1:0] in_vcnt,
  input  logic [H_BITW-1:0] in_hcnt,
  output logic              hold_load,
  output logic              buf_wr_en,
  output logic [A_BITW-1:0] buf_wr_addr,
  output logic              buf_rd_en,
  output logic [A_BITW-1:0] buf_rd_addr,
  output logic [1:0]        sel,
  output logic              out_enable,
  output logic [V_BITW-1:0] out_vcnt,
  output logic [H_BITW-1:0] out_hcnt,
  output logic              frame_done,
  output logic              sync_err
);
  localparam int STEP = 1 << LEVEL;
  localparam logic [H_BITW-1:0] H_LAST     = H_BITW'(W_WIDTH - 1);
  localparam logic [V_BITW-1:0] V_LAST     = V_BITW'(W_HEIGHT - 1);
  localparam logic [H_BITW-1:0] H_PT_MASK  = H_BITW'(STEP - 1);
  localparam logic [V_BITW-1:0] V_PT_MASK  = V_BITW'(STEP - 1);
  localparam logic [H_BITW-1:0] H_SMP_MASK = H_BITW'(2 * STEP - 1);
  localparam logic [V_BITW-1:0] V_SMP_MASK = V_BITW'(2 * STEP - 1);

  typedef enum logic [1:0] {WAIT_FRAME = 2'd0, UPPER = 2'd1, LOWER = 2'd2} state_e;

  state_e            state_q, state_d, eff;
  logic              sync_err_q, sync_err_d;
  logic [V_BITW-1:0] prev_v_q, prev_v_d, pred_v;
  logic [H_BITW-1:0] prev_h_q, prev_h_d, pred_h;

  logic              hold_load_q, hold_load_d, buf_wr_en_q, buf_wr_en_d, buf_rd_en_q, buf_rd_en_d;
  logic [A_BITW-1:0] buf_wr_addr_q, buf_wr_addr_d, buf_rd_addr_q, buf_rd_addr_d;
  logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [1:0]        s1_sel_q, s1_sel_d;
  logic [V_BITW-1:0] s1_v_q, s1_v_d;
  logic [H_BITW-1:0] s1_h_q, s1_h_d;

  logic              out_enable_q, out_enable_d, frame_done_q, frame_done_d;
  logic [1:0]        sel_q, sel_d;
  logic [V_BITW-1:0] out_vcnt_q, out_vcnt_d;
  logic [H_BITW-1:0] out_hcnt_q, out_hcnt_d;

  logic is_point, is_sample, at_origin, row_end, frame_last, band_lower, next_lower, right_half;

  assign is_point   = ((in_vcnt & V_PT_MASK) == '0) && ((in_hcnt & H_PT_MASK) == '0);
  assign is_sample  = ((in_vcnt & V_SMP_MASK) == '0) && ((in_hcnt & H_SMP_MASK) == '0);
  assign at_origin  = (in_vcnt == '0) && (in_hcnt == '0);
  assign row_end    = (in_hcnt == H_LAST);
  assign frame_last = row_end && (in_vcnt == V_LAST);
  assign band_lower = in_vcnt[LEVEL];
  assign right_half = in_hcnt[LEVEL];
  // The band flips on the row after the last row of a STEP-high band.
  assign next_lower = ((in_vcnt & V_PT_MASK) == V_PT_MASK) ? ~band_lower : band_lower;

  always_comb begin
    pred_h = prev_h_q + H_BITW'(1);
    pred_v = prev_v_q;
    if (prev_h_q == H_LAST) begin
      pred_h = '0;
      pred_v = (prev_v_q == V_LAST) ? '0 : prev_v_q + V_BITW'(1);
    end
  end

  always_comb begin
    eff        = WAIT_FRAME;
    state_d    = state_q;
    sync_err_d = sync_err_q;
    prev_v_d   = prev_v_q;
    prev_h_d   = prev_h_q;
    if (in_enable) begin
      prev_v_d = in_vcnt;
      prev_h_d = in_hcnt;
      eff      = state_q;
      if (state_q == WAIT_FRAME && at_origin) begin
        eff        = UPPER;
        sync_err_d = 1'b0;
      end else if (state_q != WAIT_FRAME && in_hcnt == '0 &&
                   (band_lower != (state_q == LOWER) || in_vcnt != pred_v || in_hcnt != pred_h)) begin
        eff        = WAIT_FRAME;
        sync_err_d = 1'b1;
      end
      state_d = eff;
      if (row_end) begin
        if (eff == UPPER && next_lower) begin
          state_d = LOWER;
        end else if (eff == LOWER) begin
          if (frame_last)       state_d = WAIT_FRAME;
          else if (!next_lower) state_d = UPPER;
        end
      end
    end
  end

  always_comb begin
    hold_load_d   = 1'b0;
    buf_wr_en_d   = 1'b0;
    buf_rd_en_d   = 1'b0;
    buf_wr_addr_d = buf_wr_addr_q;
    buf_rd_addr_d = buf_rd_addr_q;
    s1_valid_d    = 1'b0;
    s1_sel_d      = s1_sel_q;
    s1_v_d        = s1_v_q;
    s1_h_d        = s1_h_q;
    s1_last_d     = (eff == LOWER) && frame_last;
    if (eff == UPPER && is_sample) begin
      hold_load_d   = 1'b1;
      buf_wr_en_d   = 1'b1;
      buf_wr_addr_d = A_BITW'(in_hcnt >> (LEVEL + 1));
    end
    if (eff == LOWER && is_point) begin
      buf_rd_en_d   = 1'b1;
      buf_rd_addr_d = A_BITW'(in_hcnt >> (LEVEL + 1));
    end
    if (eff != WAIT_FRAME && is_point) begin
      s1_valid_d = 1'b1;
      s1_sel_d   = (eff == LOWER) ? 2'd2 : (right_half ? 2'd1 : 2'd0);
      s1_v_d     = in_vcnt;
      s1_h_d     = in_hcnt;
    end
  end

  // Stage 2 lines up with line-buffer read data (one cycle after buf_rd_en).
  always_comb begin
    out_enable_d = s1_valid_q;
    frame_done_d = s1_last_q;
    sel_d        = sel_q;
    out_vcnt_d   = out_vcnt_q;
    out_hcnt_d   = out_hcnt_q;
    if (s1_valid_q) begin
      sel_d      = s1_sel_q;
      out_vcnt_d = s1_v_q;
      out_hcnt_d = s1_h_q;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= WAIT_FRAME;
      sync_err_q    <= 1'b0;
      prev_v_q      <= '0;
      prev_h_q      <= '0;
      hold_load_q   <= 1'b0;
      buf_wr_en_q   <= 1'b0;
      buf_rd_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_rd_addr_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_sel_q      <= '0;
      s1_v_q        <= '0;
      s1_h_q        <= '0;
      out_enable_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      sel_q         <= '0;
      out_vcnt_q    <= '0;
      out_hcnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      sync_err_q    <= sync_err_d;
      prev_v_q      <= prev_v_d;
      prev_h_q      <= prev_h_d;
      hold_load_q   <= hold_load_d;
      buf_wr_en_q   <= buf_wr_en_d;
      buf_rd_en_q   <= buf_rd_en_d;
      buf_wr_addr_q <= buf_wr_addr_d;
      buf_rd_addr_q <= buf_rd_addr_d;
      s1_valid_q    <= s1_valid_d;
      s1_last_q     <= s1_last_d;
      s1_sel_q      <= s1_sel_d;
      s1_v_q        <= s1_v_d;
      s1_h_q        <= s1_h_d;
      out_enable_q  <= out_enable_d;
      frame_done_q  <= frame_done_d;
      sel_q         <= sel_d;
      out_vcnt_q    <= out_vcnt_d;
      out_hcnt_q    <= out_hcnt_d;
    end
  end

  assign hold_load   = hold_load_q;
  assign buf_wr_en   = buf_wr_en_q;
  assign buf_wr_addr = buf_wr_addr_q;
  assign buf_rd_en   = buf_rd_en_q;
  assign buf_rd_addr = buf_rd_addr_q;
  assign sel         = sel_q;
  assign out_enable  = out_enable_q;
  assign out_vcnt    = out_vcnt_q;
  assign out_hcnt    = out_hcnt_q;
  assign frame_done  = frame_done_q;
  assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_unpool_sequencer.sv
// tb/tb_unpool_sequencer.sv - directed bench: LEVEL=1 16x8 and LEVEL=0 8x4 sequencers
module tb_unpool_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       en_a, hold_a, wr_a, rd_a, oe_a, fd_a, err_a;
  logic [2:0] v_a, ov_a;
  logic [3:0] h_a, oh_a;
  logic [1:0] wra_a, rda_a, sel_a;

  logic       en_b, hold_b, wr_b, rd_b, oe_b, fd_b, err_b;
  logic [1:0] v_b, ov_b;
  logic [2:0] h_b, oh_b;
  logic [1:0] wra_b, rda_b, sel_b;

  unpool_sequencer #(.W_WIDTH(16), .W_HEIGHT(8), .LEVEL(1)) dut_a (
    .clock(clk), .n_rst(rst_n), .in_enable(en_a), .in_vcnt(v_a), .in_hcnt(h_a),
    .hold_load(hold_a), .buf_wr_en(wr_a), .buf_wr_addr(wra_a), .buf_rd_en(rd_a),
    .buf_rd_addr(rda_a), .sel(sel_a), .out_enable(oe_a), .out_vcnt(ov_a),
    .out_hcnt(oh_a), .frame_done(fd_a), .sync_err(err_a));

  unpool_sequencer #(.W_WIDTH(8), .W_HEIGHT(4), .LEVEL(0)) dut_b (
    .clock(clk), .n_rst(rst_n), .in_enable(en_b), .in_vcnt(v_b), .in_hcnt(h_b),
    .hold_load(hold_b), .buf_wr_en(wr_b), .buf_wr_addr(wra_b), .buf_rd_en(rd_b),
    .buf_rd_addr(rda_b), .sel(sel_b), .out_enable(oe_b), .out_vcnt(ov_b),
    .out_hcnt(oh_b), .frame_done(fd_b), .sync_err(err_b));

  int vectors = 0;
  int miscompares = 0;
  int cur, lvl, fw, fh;
  logic p_oe, p_last, exp_err;
  int p_sel, p_v, p_h;
  int oe_count, fd_count;
  int out_log[$];
  int wr_log[$];
  int rd_log[$];
  int ref_log[$];
  int exp8[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    oe_count = 0;
    fd_count = 0;
    out_log.delete();
    wr_log.delete();
    rd_log.delete();
  endtask

  task automatic step(input logic en, input int v, input int h, input logic act);
    int st;
    logic pt, smp, up, rt;
    logic o_hold, o_wr, o_rd, o_oe, o_fd, o_err;
    logic [1:0] o_wra, o_rda, o_sel;
    logic [2:0] o_v;
    logic [3:0] o_h;
    st = 1 << lvl;
    if (cur == 0) begin
      en_a = en; v_a = 3'(v); h_a = 4'(h);
    end else begin
      en_b = en; v_b = 2'(v); h_b = 3'(h);
    end
    @(posedge clk);
    #1;
    if (cur == 0) begin
      o_hold = hold_a; o_wr = wr_a; o_wra = wra_a; o_rd = rd_a; o_rda = rda_a; o_sel = sel_a;
      o_oe = oe_a; o_v = ov_a; o_h = oh_a; o_fd = fd_a; o_err = err_a;
    end else begin
      o_hold = hold_b; o_wr = wr_b; o_wra = wra_b; o_rd = rd_b; o_rda = rda_b; o_sel = sel_b;
      o_oe = oe_b; o_v = {1'b0, ov_b}; o_h = {1'b0, oh_b}; o_fd = fd_b; o_err = err_b;
    end
    pt  = en && act && (v % st == 0) && (h % st == 0);
    smp = pt && (v % (2 * st) == 0) && (h % (2 * st) == 0);
    up  = ((v >> lvl) & 1) == 0;
    rt  = ((h >> lvl) & 1) == 1;
    check("hold_load", 32'(o_hold), 32'(smp && up));
    check("buf_wr_en", 32'(o_wr), 32'(smp && up));
    if (smp && up) check("buf_wr_addr", 32'(o_wra), h >> (lvl + 1));
    check("buf_rd_en", 32'(o_rd), 32'(pt && !up));
    if (pt && !up) check("buf_rd_addr", 32'(o_rda), h >> (lvl + 1));
    check("out_enable", 32'(o_oe), 32'(p_oe));
    if (p_oe) begin
      check("sel", 32'(o_sel), p_sel);
      check("out_vcnt", 32'(o_v), p_v);
      check("out_hcnt", 32'(o_h), p_h);
    end
    check("frame_done", 32'(o_fd), 32'(p_last));
    check("sync_err", 32'(o_err), 32'(exp_err));
    if (o_oe === 1'b1) begin
      oe_count++;
      out_log.push_back(int'(o_sel) * 256 + int'(o_v) * 16 + int'(o_h));
    end
    if (o_fd === 1'b1) fd_count++;
    if (o_wr === 1'b1) wr_log.push_back(v * 16 + int'(o_wra));
    if (o_rd === 1'b1) rd_log.push_back(v * 16 + int'(o_rda));
    p_oe   = pt;
    p_sel  = up ? (rt ? 1 : 0) : 2;
    p_v    = v;
    p_h    = h;
    p_last = en && act && (v == fh - 1) && (h == fw - 1);
  endtask

  task automatic run_rows(input int v0, input int v1, input logic act, input int bubble_pct);
    for (int v = v0; v <= v1; v++) begin
      for (int h = 0; h < fw; h++) begin
        if (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) step(1'b0, v, h, 1'b0);
        step(1'b1, v, h, act);
      end
    end
  endtask

  task automatic flush();
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_reset_a();
    check("rst hold_load", 32'(hold_a), 0);
    check("rst buf_wr_en", 32'(wr_a), 0);
    check("rst buf_wr_addr", 32'(wra_a), 0);
    check("rst buf_rd_en", 32'(rd_a), 0);
    check("rst buf_rd_addr", 32'(rda_a), 0);
    check("rst sel", 32'(sel_a), 0);
    check("rst out_enable", 32'(oe_a), 0);
    check("rst out_vcnt", 32'(ov_a), 0);
    check("rst out_hcnt", 32'(oh_a), 0);
    check("rst frame_done", 32'(fd_a), 0);
    check("rst sync_err", 32'(err_a), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    en_a = 0; v_a = 0; h_a = 0; en_b = 0; v_b = 0; h_b = 0;
    cur = 0; lvl = 1; fw = 16; fh = 8;
    exp_err = 0; p_oe = 0; p_last = 0; p_sel = 0; p_v = 0; p_h = 0;
    #2 rst_n = 1'b0;
    #1 check_reset_a();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // LEVEL=1 16x8, continuous
    clear_logs();
    run_rows(0, 7, 1'b1, 0);
    flush();
    check("f1 out count", oe_count, 32);
    check("f1 frame_done count", fd_count, 1);
    exp8 = '{0, 258, 4, 262, 8, 266, 12, 270};
    for (int k = 0; k < 8; k++) check("f1 row0 sel/hcnt", out_log[k], exp8[k]);
    for (int k = 0; k < 8; k++) check("f1 row2 sel/hcnt", out_log[8 + k], 544 + 2 * k);
    exp8 = '{32, 32, 33, 33, 34, 34, 35, 35};
    for (int k = 0; k < 8; k++) check("f1 row2 rd_addr", rd_log[k], exp8[k]);
    for (int k = 0; k < 8; k++) check("f1 row6 rd_addr", rd_log[8 + k], exp8[k] + 64);
    check("f1 rd count", rd_log.size(), 16);
    exp8 = '{0, 1, 2, 3, 64, 65, 66, 67};
    check("f1 wr count", wr_log.size(), 8);
    for (int k = 0; k < 8; k++) check("f1 wr row/addr", wr_log[k], exp8[k]);
    ref_log = out_log;

    // same frame with ~30% bubbles
    clear_logs();
    run_rows(0, 7, 1'b1, 30);
    flush();
    check("bubble out count", oe_count, 32);
    check("bubble frame_done count", fd_count, 1);
    for (int k = 0; k < 32; k++) check("bubble out seq", out_log[k], ref_log[k]);

    // row 1 jumps to row 4
    clear_logs();
    run_rows(0, 1, 1'b1, 0);
    exp_err = 1'b1;
    run_rows(4, 7, 1'b0, 0);
    flush();
    check("jump out count", oe_count, 8);
    check("jump frame_done count", fd_count, 0);
    exp_err = 1'b0;
    clear_logs();
    run_rows(0, 7, 1'b1, 0);
    flush();
    check("post-jump out count", oe_count, 32);
    check("post-jump frame_done count", fd_count, 1);

    // reset in the middle of row 5
    clear_logs();
    run_rows(0, 4, 1'b1, 0);
    for (int h = 0; h < 8; h++) step(1'b1, 5, h, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset_a();
    p_oe = 0;
    p_last = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int h = 8; h < 16; h++) step(1'b1, 5, h, 1'b0);
    run_rows(6, 7, 1'b0, 0);
    flush();
    check("rst-frame out count", oe_count, 24);
    check("rst-frame frame_done count", fd_count, 0);
    clear_logs();
    run_rows(0, 7, 1'b1, 0);
    flush();
    check("post-rst out count", oe_count, 32);
    check("post-rst frame_done count", fd_count, 1);
    for (int k = 0; k < 32; k++) check("post-rst out seq", out_log[k], ref_log[k]);

    // LEVEL=0 8x4
    cur = 1; lvl = 0; fw = 8; fh = 4;
    p_oe = 0; p_last = 0;
    clear_logs();
    run_rows(0, 3, 1'b1, 0);
    flush();
    check("L0 out count", oe_count, 32);
    check("L0 frame_done count", fd_count, 1);
    exp8 = '{0, 257, 2, 259, 4, 261, 6, 263};
    for (int k = 0; k < 8; k++) check("L0 row0 sel/hcnt", out_log[k], exp8[k]);
    for (int k = 0; k < 8; k++) check("L0 row1 sel/hcnt", out_log[8 + k], 528 + k);
    exp8 = '{16, 16, 17, 17, 18, 18, 19, 19};
    for (int k = 0; k < 8; k++) check("L0 row1 rd_addr", rd_log[k], exp8[k]);
    exp8 = '{0, 1, 2, 3, 32, 33, 34, 35};
    check("L0 wr count", wr_log.size(), 8);
    for (int k = 0; k < 8; k++) check("L0 wr row/addr", wr_log[k], exp8[k]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
